// File: rtl/bram_arb_pkg.sv
// bram_arb_pkg: shared types and constants for the two-client BRAM arbiter.
//   NCLIENT     number of requesters
//   client_t    requester index
//   addr_width  word-address width for a given BRAM depth
package bram_arb_pkg;

  localparam int unsigned NCLIENT = 2;

  typedef logic [0:0] client_t;

  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth > 32'd1) ? 32'($clog2(depth)) : 32'd1;
  endfunction

endpackage

// File: rtl/bram_arb_if.sv
// bram_arb_if: one client's request/response channel to the BRAM arbiter.
//   req__ENA/req_write/req_addr/req_data  request fire and payload (client -> arbiter)
//   req__RDY                              grant (arbiter -> client)
//   rsp__ENA                              response dequeue (client -> arbiter)
//   rsp/rsp__RDY                          read data and slot valid (arbiter -> client)
// Modports: master = client side, slave = arbiter side.
interface bram_arb_if #(
  parameter int unsigned width = 4,
  parameter int unsigned depth = 1024
);
  import bram_arb_pkg::*;

  localparam int unsigned AW = addr_width(depth);

  logic             req__ENA;
  logic             req_write;
  logic [AW-1:0]    req_addr;
  logic [width-1:0] req_data;
  logic             req__RDY;
  logic             rsp__ENA;
  logic [width-1:0] rsp;
  logic             rsp__RDY;

  modport master (
    output req__ENA, req_write, req_addr, req_data, rsp__ENA,
    input  req__RDY, rsp, rsp__RDY
  );

  modport slave (
    input  req__ENA, req_write, req_addr, req_data, rsp__ENA,
    output req__RDY, rsp, rsp__RDY
  );

endinterface

// File: rtl/bram_arb_rsp_slot.sv
// bram_arb_rsp_slot: one-entry response holder for a single client.
//   CLK, RST        clock, async active-high reset
//   load/load_data  capture returning read data and mark the slot valid
//   deq             clear the valid flag (data is retained)
//   valid/data      slot contents
module bram_arb_rsp_slot #(
  parameter int unsigned width = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             load,
  input  logic [width-1:0] load_data,
  input  logic             deq,
  output logic             valid,
  output logic [width-1:0] data
);

  // A load can never coincide with a valid slot, so load simply wins over deq.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (deq) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/bram_arbiter.sv
// bram_arbiter: two-client round-robin arbiter in front of a single-port BRAM.
//   CLK, RST                      clock, async active-high reset
//   c0, c1                        client channels (bram_arb_if.slave)
//   write__ENA/write_addr/_data   BRAM write method
//   read__ENA/read_addr           BRAM read method
//   dataOut                       BRAM registered read data (valid the cycle after read__ENA)
// Build option: define BRAM_ARB_FIXED_PRIO_EN to give client 0 strict priority
// (no token register); otherwise clients are served round-robin.
module bram_arbiter
  import bram_arb_pkg::*;
#(
  parameter int unsigned width = 4,
  parameter int unsigned depth = 1024,
  localparam int unsigned AW = addr_width(depth)
) (
  input  logic             CLK,
  input  logic             RST,
  bram_arb_if.slave        c0,
  bram_arb_if.slave        c1,
  output logic             write__ENA,
  output logic [AW-1:0]    write_addr,
  output logic [width-1:0] write_data,
  output logic             read__ENA,
  output logic [AW-1:0]    read_addr,
  input  logic [width-1:0] dataOut
);

  logic                init_done;
  logic                inflight;
  client_t             inflight_tag;
  logic [NCLIENT-1:0]  rsp_valid;
  logic [NCLIENT-1:0]  elig;
  logic [NCLIENT-1:0]  rdy;
  logic [NCLIENT-1:0]  ena;
  logic [NCLIENT-1:0]  fire;
  logic [NCLIENT-1:0]  wr;
  logic [NCLIENT-1:0]  deq;
  logic [AW-1:0]       addr      [NCLIENT];
  logic [width-1:0]    wdata     [NCLIENT];
  logic [width-1:0]    rsp_data  [NCLIENT];
  client_t             sel;

  // Flatten the two client channels into indexable vectors.
  assign ena      = {c1.req__ENA, c0.req__ENA};
  assign wr       = {c1.req_write, c0.req_write};
  assign deq      = {c1.rsp__ENA, c0.rsp__ENA};
  assign addr[0]  = c0.req_addr;
  assign addr[1]  = c1.req_addr;
  assign wdata[0] = c0.req_data;
  assign wdata[1] = c1.req_data;

  // A client is eligible only with an empty slot and no read of its own in flight.
  always_comb begin
    elig = '0;
    for (int i = 0; i < int'(NCLIENT); i++) begin
      elig[i] = init_done && !rsp_valid[i] && !(inflight && inflight_tag == client_t'(i));
    end
  end

`ifdef BRAM_ARB_FIXED_PRIO_EN
  assign rdy = {elig[1] && !elig[0], elig[0]};
`else
  client_t token;

  assign rdy = {elig[1] && (!elig[0] || token == 1'b1),
                elig[0] && (!elig[1] || token == 1'b0)};

  // Token toggles every cycle while both contend, else passes away from the last firer.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      token <= '0;
    end else if (&elig) begin
      token <= ~token;
    end else if (fire[0]) begin
      token <= 1'b1;
    end else if (fire[1]) begin
      token <= 1'b0;
    end
  end
`endif

  // Ready is exclusive, so at most one bit of fire is set.
  assign fire = ena & rdy;
  assign sel  = client_t'(fire[1]);

  // Pass the granted request straight through to the BRAM methods.
  always_comb begin
    write__ENA = 1'b0;
    write_addr = '0;
    write_data = '0;
    read__ENA  = 1'b0;
    read_addr  = '0;
    if (|fire) begin
      if (wr[sel]) begin
        write__ENA = 1'b1;
        write_addr = addr[sel];
        write_data = wdata[sel];
      end else begin
        read__ENA = 1'b1;
        read_addr = addr[sel];
      end
    end
  end

  // init_done holds off grants for the BRAM's first post-reset cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      init_done    <= 1'b0;
      inflight     <= 1'b0;
      inflight_tag <= '0;
    end else begin
      init_done <= 1'b1;
      inflight  <= read__ENA;
      if (read__ENA) begin
        inflight_tag <= sel;
      end
    end
  end

  for (genvar i = 0; i < int'(NCLIENT); i++) begin : g_slot
    bram_arb_rsp_slot #(.width(width)) u_slot (
      .CLK       (CLK),
      .RST       (RST),
      .load      (inflight && inflight_tag == client_t'(i)),
      .load_data (dataOut),
      .deq       (deq[i]),
      .valid     (rsp_valid[i]),
      .data      (rsp_data[i])
    );
  end

  assign c0.req__RDY = rdy[0];
  assign c1.req__RDY = rdy[1];
  assign c0.rsp__RDY = rsp_valid[0];
  assign c1.rsp__RDY = rsp_valid[1];
  assign c0.rsp      = rsp_data[0];
  assign c1.rsp      = rsp_data[1];

endmodule
